// File: rtl/trap_ctrl_pkg.sv
// Shared constants and state encoding for the machine-mode trap sequencer.
package trap_ctrl_pkg;

    localparam int unsigned TRAP_CPU_WIDTH = 64;

    localparam int unsigned CAUSE_ECALL_M = 11;
    localparam int unsigned CAUSE_MTI     = 7;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSave = 2'd1,
        StStat = 2'd2,
        StJump = 2'd3
    } trap_state_e;

endpackage

// File: rtl/trap_ctrl_stdreg.sv
// Enabled register with synchronous active-high reset to zero.
module trap_ctrl_stdreg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: takes ecall/mret/timer irq at commit, writes
// mepc/mcause/mstatus over a fixed sequence, then redirects the IFU.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned CPU_WIDTH = TRAP_CPU_WIDTH,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic [CPU_WIDTH-1:0] i_pc,
    input  logic                 i_ecall,
    input  logic                 i_mret,
    input  logic                 i_irq_timer,
    input  logic [CPU_WIDTH-1:0] i_mtvec,
    input  logic [CPU_WIDTH-1:0] i_mepc,
    input  logic [CPU_WIDTH-1:0] i_mstatus,
    output logic                 o_accept,
    output logic                 o_stall,
    output logic                 o_mepc_wen,
    output logic [CPU_WIDTH-1:0] o_mepc_wdata,
    output logic                 o_mcause_wen,
    output logic [CPU_WIDTH-1:0] o_mcause_wdata,
    output logic                 o_mstatus_wen,
    output logic [CPU_WIDTH-1:0] o_mstatus_wdata,
    output logic                 o_redirect,
    output logic [CPU_WIDTH-1:0] o_redirect_pc,
    output logic [CNT_WIDTH-1:0] o_trap_cnt
);

    localparam logic [CPU_WIDTH-1:0] CauseEcallW = CPU_WIDTH'(CAUSE_ECALL_M);
    localparam logic [CPU_WIDTH-1:0] CauseMtiW   = {1'b1, (CPU_WIDTH-1)'(CAUSE_MTI)};

    trap_state_e r_state, w_state_d;
    logic        r_stall;

    logic                 w_take_irq, w_take_ecall, w_take_mret, w_accept;
    logic [CPU_WIDTH-1:0] w_cause_d;
    logic [CPU_WIDTH-1:0] w_ms_trap, w_ms_mret, w_tvec_base;
    logic [CPU_WIDTH-3:0] r_pc;
    logic [CPU_WIDTH-1:0] r_cause;
    logic                 r_is_irq, r_is_mret;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 w_cnt_en;
    logic                 w_unused_bits;

    // mepc/redirect targets are word-aligned, so the low PC bits never matter.
    assign w_unused_bits = ^{i_pc[1:0], i_mepc[1:0]};

    trap_ctrl_stdreg #(.WIDTH(CPU_WIDTH-2)) u_pc_reg (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (w_accept),
        .i_d   (i_pc[CPU_WIDTH-1:2]),
        .o_q   (r_pc)
    );

    trap_ctrl_stdreg #(.WIDTH(CPU_WIDTH)) u_cause_reg (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (w_accept),
        .i_d   (w_cause_d),
        .o_q   (r_cause)
    );

    trap_ctrl_stdreg #(.WIDTH(2)) u_flag_reg (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (w_accept),
        .i_d   ({w_take_irq, ~w_take_irq & ~w_take_ecall}),
        .o_q   ({r_is_irq, r_is_mret})
    );

    trap_ctrl_stdreg #(.WIDTH(CNT_WIDTH)) u_cnt_reg (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (w_cnt_en),
        .i_d   (r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1}),
        .o_q   (r_cnt)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_stall <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_stall <= (w_state_d != StIdle);
        end
    end

    always_comb begin
        w_state_d       = r_state;
        w_accept        = 1'b0;
        w_cnt_en        = 1'b0;
        o_mepc_wen      = 1'b0;
        o_mepc_wdata    = '0;
        o_mcause_wen    = 1'b0;
        o_mcause_wdata  = '0;
        o_mstatus_wen   = 1'b0;
        o_mstatus_wdata = '0;
        o_redirect      = 1'b0;
        o_redirect_pc   = '0;

        w_take_irq   = i_valid & i_irq_timer & i_mstatus[MSTATUS_MIE];
        w_take_ecall = i_valid & i_ecall;
        w_take_mret  = i_valid & i_mret;
        w_cause_d    = w_take_irq ? CauseMtiW : (w_take_ecall ? CauseEcallW : '0);

        w_ms_trap                                = i_mstatus;
        w_ms_trap[MSTATUS_MPIE]                  = i_mstatus[MSTATUS_MIE];
        w_ms_trap[MSTATUS_MIE]                   = 1'b0;
        w_ms_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

        w_ms_mret                                = i_mstatus;
        w_ms_mret[MSTATUS_MIE]                   = i_mstatus[MSTATUS_MPIE];
        w_ms_mret[MSTATUS_MPIE]                  = 1'b1;
        w_ms_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

        w_tvec_base = {i_mtvec[CPU_WIDTH-1:2], 2'b00};

        unique case (r_state)
            StIdle: begin
                w_accept = w_take_irq | w_take_ecall | w_take_mret;
                if (w_take_irq || w_take_ecall) begin
                    w_state_d = StSave;
                end else if (w_take_mret) begin
                    w_state_d = StStat;
                end
            end
            StSave: begin
                w_cnt_en       = 1'b1;
                o_mepc_wen     = 1'b1;
                o_mepc_wdata   = {r_pc, 2'b00};
                o_mcause_wen   = 1'b1;
                o_mcause_wdata = r_cause;
                w_state_d      = StStat;
            end
            StStat: begin
                o_mstatus_wen   = 1'b1;
                o_mstatus_wdata = r_is_mret ? w_ms_mret : w_ms_trap;
                w_state_d       = StJump;
            end
            StJump: begin
                o_redirect = 1'b1;
                if (r_is_mret) begin
                    o_redirect_pc = {i_mepc[CPU_WIDTH-1:2], 2'b00};
                end else if (r_is_irq && i_mtvec[1:0] == 2'b01) begin
                    // Vectored mode: 4 * cause without the interrupt bit.
                    o_redirect_pc = w_tvec_base + {r_cause[CPU_WIDTH-3:0], 2'b00};
                end else begin
                    o_redirect_pc = w_tvec_base;
                end
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase

        // Reset aborts in-flight sequences: no accept, write or redirect this cycle.
        if (i_rst) begin
            w_accept        = 1'b0;
            o_mepc_wen      = 1'b0;
            o_mepc_wdata    = '0;
            o_mcause_wen    = 1'b0;
            o_mcause_wdata  = '0;
            o_mstatus_wen   = 1'b0;
            o_mstatus_wdata = '0;
            o_redirect      = 1'b0;
            o_redirect_pc   = '0;
        end
    end

    assign o_accept   = w_accept;
    assign o_stall    = r_stall;
    assign o_trap_cnt = r_cnt;

endmodule
